// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, synchronous flush
// to a NOP bubble, and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load_main;
  logic              w_main_from_skid;
  logic              w_load_skid;
  logic              w_in_fire;
  logic              w_stall;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Handshake only consults registered state, so out_ready never reaches in_ready.
  assign w_in_fire = in_valid & (r_state != TWO);
  assign w_stall   = (r_state != EMPTY) & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_load_main = 1'b1;
          w_state_nxt = ONE;
        end else begin
          w_state_nxt = EMPTY;
        end
      end
      ONE: begin
        if (w_in_fire && out_ready) begin
          w_load_main = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid = 1'b1;
          w_state_nxt = TWO;
        end else if (out_ready) begin
          w_state_nxt = EMPTY;
        end else begin
          w_state_nxt = ONE;
        end
      end
      TWO: begin
        if (out_ready) begin
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = ONE;
        end else begin
          w_state_nxt = TWO;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
    // Flush wins over everything and drops any entry offered this cycle.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= {DATA_W{1'b0}};
      r_main_ctrl <= CTRL_NOP;
      r_skid_data <= {DATA_W{1'b0}};
      r_skid_ctrl <= CTRL_NOP;
    end else begin
      if (w_load_main && w_main_from_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end else if (w_load_main) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_valid = (r_state != EMPTY);
  assign in_ready  = (r_state != TWO);
  assign out_data  = r_main_data;
  assign out_ctrl  = out_valid ? r_main_ctrl : CTRL_NOP;
  assign stall_cnt = r_stall_cnt;

endmodule
